// File: rtl/shifter_operand_stage.sv
// ARM data-processing shifter operand stage: forms operand and carry-out from Rm,
// shift type and amount, then holds them in a one-entry valid/ready output register.
module shifter_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rm_data,
    input  logic [1:0]  shift_type,
    input  logic        shift_by_reg,
    input  logic [4:0]  imm_shift,
    input  logic [7:0]  rs_data,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand,
    output logic        shifter_carry
);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    shift_e      w_type;
    logic [7:0]  w_amt;
    logic [4:0]  w_amt5;
    logic [32:0] w_lsl_wide;
    logic [32:0] w_lsr_wide;
    logic [32:0] w_asr_wide;
    logic [63:0] w_ror_wide;
    logic [31:0] w_operand;
    logic        w_carry;
    logic        w_accept;

    logic [31:0] r_operand;
    logic        r_carry;
    logic        r_valid;

    assign w_type = shift_e'(shift_type);
    assign w_amt  = shift_by_reg ? rs_data : {3'b000, imm_shift};
    assign w_amt5 = w_amt[4:0];

    // The extra 33rd bit catches the last bit shifted out, which is the carry.
    assign w_lsl_wide = {1'b0, rm_data} << w_amt5;
    assign w_lsr_wide = {rm_data, 1'b0} >> w_amt5;
    assign w_asr_wide = 33'($signed({rm_data, 1'b0}) >>> w_amt5);
    assign w_ror_wide = {rm_data, rm_data} >> w_amt5;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_operand = rm_data;
        w_carry   = carry_in;
        if (!shift_by_reg && imm_shift == 5'd0) begin
            // Immediate zero encodes LSR/ASR #32 and RRX; LSL #0 passes Rm through.
            unique case (w_type)
                SH_LSL: ;
                SH_LSR: begin w_operand = 32'd0;             w_carry = rm_data[31]; end
                SH_ASR: begin w_operand = {32{rm_data[31]}}; w_carry = rm_data[31]; end
                SH_ROR: begin w_operand = {carry_in, rm_data[31:1]}; w_carry = rm_data[0]; end
            endcase
        end else if (w_amt != 8'd0) begin
            unique case (w_type)
                SH_LSL: begin
                    if (w_amt < 8'd32) begin
                        w_operand = w_lsl_wide[31:0];
                        w_carry   = w_lsl_wide[32];
                    end else begin
                        w_operand = 32'd0;
                        w_carry   = (w_amt == 8'd32) ? rm_data[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (w_amt < 8'd32) begin
                        w_operand = w_lsr_wide[32:1];
                        w_carry   = w_lsr_wide[0];
                    end else begin
                        w_operand = 32'd0;
                        w_carry   = (w_amt == 8'd32) ? rm_data[31] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (w_amt < 8'd32) begin
                        w_operand = w_asr_wide[32:1];
                        w_carry   = w_asr_wide[0];
                    end else begin
                        w_operand = {32{rm_data[31]}};
                        w_carry   = rm_data[31];
                    end
                end
                SH_ROR: begin
                    w_operand = (w_amt5 == 5'd0) ? rm_data : w_ror_wide[31:0];
                    w_carry   = (w_amt5 == 5'd0) ? rm_data[31] : w_ror_wide[31];
                end
            endcase
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // NOTE: state is updated only with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data registers are reset too, since the outputs must read zero after reset.
            r_valid   <= 1'b0;
            r_operand <= 32'd0;
            r_carry   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_operand <= w_operand;
            r_carry   <= w_carry;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign operand       = r_operand;
    assign shifter_carry = r_carry;

endmodule

// File: tb/tb_shifter_operand_stage.sv
// Directed self-checking bench for shifter_operand_stage: shift encodings,
// handshake back-pressure, flush and reset behaviour.
module tb_shifter_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rm_data;
    logic [1:0]  shift_type;
    logic        shift_by_reg;
    logic [4:0]  imm_shift;
    logic [7:0]  rs_data;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand;
    logic        shifter_carry;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

    shifter_operand_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rm_data       (rm_data),
        .shift_type    (shift_type),
        .shift_by_reg  (shift_by_reg),
        .imm_shift     (imm_shift),
        .rs_data       (rs_data),
        .carry_in      (carry_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .operand       (operand),
        .shifter_carry (shifter_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] rm, input logic [1:0] typ, input logic byreg,
                         input logic [4:0] imm, input logic [7:0] rs, input logic cin);
        in_valid     = 1'b1;
        rm_data      = rm;
        shift_type   = typ;
        shift_by_reg = byreg;
        imm_shift    = imm;
        rs_data      = rs;
        carry_in     = cin;
    endtask

    // One accepted operation with out_ready high; result is checked the next cycle.
    task automatic op(input string tag, input logic [31:0] rm, input logic [1:0] typ,
                      input logic byreg, input logic [4:0] imm, input logic [7:0] rs,
                      input logic cin, input logic [31:0] exp_op, input logic exp_c);
        drive(rm, typ, byreg, imm, rs, cin);
        out_ready = 1'b1;
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_op"}, operand, exp_op);
        check({tag, "_c"}, {31'd0, shifter_carry}, {31'd0, exp_c});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(32'hDEAD_BEEF, LSL, 1'b0, 5'd3, 8'd0, 1'b1);

        // Reset for two cycles with a request pending.
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op", operand, 32'd0);
        check("rst_c", {31'd0, shifter_carry}, 32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Immediate special encodings.
        op("imm_lsl0", 32'h8000_0001, LSL, 1'b0, 5'd0, 8'd0, 1'b0, 32'h8000_0001, 1'b0);
        op("imm_lsr0", 32'h8000_0001, LSR, 1'b0, 5'd0, 8'd0, 1'b0, 32'h0000_0000, 1'b1);
        op("imm_asr0", 32'h8000_0001, ASR, 1'b0, 5'd0, 8'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("imm_rrx",  32'h8000_0001, ROR, 1'b0, 5'd0, 8'd0, 1'b1, 32'hC000_0000, 1'b1);

        // Register amounts.
        op("reg_lsl32",  32'h8000_0001, LSL, 1'b1, 5'd0, 8'd32,  1'b0, 32'h0000_0000, 1'b1);
        op("reg_lsl33",  32'h8000_0001, LSL, 1'b1, 5'd0, 8'd33,  1'b1, 32'h0000_0000, 1'b0);
        op("reg_lsr32",  32'h8000_0001, LSR, 1'b1, 5'd0, 8'd32,  1'b0, 32'h0000_0000, 1'b1);
        op("reg_lsr200", 32'h8000_0001, LSR, 1'b1, 5'd0, 8'd200, 1'b1, 32'h0000_0000, 1'b0);
        op("reg_asr255", 32'h8000_0001, ASR, 1'b1, 5'd0, 8'd255, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("reg_asr32p", 32'h7FFF_FFFF, ASR, 1'b1, 5'd0, 8'd32,  1'b1, 32'h0000_0000, 1'b0);
        op("reg_ror64",  32'h8000_0001, ROR, 1'b1, 5'd0, 8'd64,  1'b0, 32'h8000_0001, 1'b1);
        op("reg_ror4",   32'h8000_0001, ROR, 1'b1, 5'd0, 8'd4,   1'b1, 32'h1800_0000, 1'b0);
        op("reg0_lsl",   32'h1234_5678, LSL, 1'b1, 5'd7, 8'd0,   1'b1, 32'h1234_5678, 1'b1);
        op("reg0_lsr",   32'h1234_5678, LSR, 1'b1, 5'd7, 8'd0,   1'b1, 32'h1234_5678, 1'b1);
        op("reg0_asr",   32'h1234_5678, ASR, 1'b1, 5'd7, 8'd0,   1'b1, 32'h1234_5678, 1'b1);
        op("reg0_ror",   32'h1234_5678, ROR, 1'b1, 5'd7, 8'd0,   1'b1, 32'h1234_5678, 1'b1);

        // Normal shifts; these four also form a back-to-back stream of four results.
        op("imm_lsr4", 32'hF000_000F, LSR, 1'b0, 5'd4, 8'd0, 1'b0, 32'h0F00_0000, 1'b1);
        op("imm_asr4", 32'hF000_000F, ASR, 1'b0, 5'd4, 8'd0, 1'b0, 32'hFF00_0000, 1'b1);
        op("imm_lsl4", 32'hF000_000F, LSL, 1'b0, 5'd4, 8'd0, 1'b0, 32'h0000_00F0, 1'b1);
        op("imm_ror8", 32'h1234_5678, ROR, 1'b0, 5'd8, 8'd0, 1'b1, 32'h7812_3456, 1'b0);

        // Back-pressure: hold E for three cycles while F waits at the input.
        op("bp_e", 32'h0000_0011, LSL, 1'b0, 5'd1, 8'd0, 1'b0, 32'h0000_0022, 1'b0);
        out_ready = 1'b0;
        drive(32'h0000_0100, LSR, 1'b0, 5'd4, 8'd0, 1'b0);
        #1;
        check("bp_in_ready_lo", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_op", operand, 32'h0000_0022);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_hi", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_f_valid", {31'd0, out_valid}, 32'd1);
        check("bp_f_op", operand, 32'h0000_0010);
        op("bp_g", 32'h0000_0003, ROR, 1'b0, 5'd1, 8'd0, 1'b0, 32'h8000_0001, 1'b1);
        in_valid = 1'b0;
        tick();
        check("bp_drain", {31'd0, out_valid}, 32'd0);

        // Flush during a stall with a new request present.
        op("fl_h", 32'hAAAA_AAAA, LSL, 1'b0, 5'd0, 8'd0, 1'b0, 32'hAAAA_AAAA, 1'b0);
        out_ready = 1'b0;
        flush = 1'b1;
        drive(32'h0000_0005, LSL, 1'b0, 5'd2, 8'd0, 1'b0);
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        op("fl_after", 32'h0000_0001, LSL, 1'b0, 5'd3, 8'd0, 1'b0, 32'h0000_0008, 1'b0);

        // Flush beats a same-cycle accept.
        flush = 1'b1;
        drive(32'h0000_0007, LSL, 1'b0, 5'd1, 8'd0, 1'b0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_acc_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("fl_acc_stays", {31'd0, out_valid}, 32'd0);

        // Reset mid-stall drops the held result.
        op("rs_k", 32'h0000_00FF, LSL, 1'b0, 5'd4, 8'd0, 1'b0, 32'h0000_0FF0, 1'b0);
        out_ready = 1'b0;
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check("rs_valid", {31'd0, out_valid}, 32'd0);
        check("rs_op", operand, 32'd0);
        check("rs_c", {31'd0, shifter_carry}, 32'd0);
        check("rs_in_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_operand_stage.md
# shifter_operand_stage

Registered pipeline stage that forms the ARM data-processing shifter operand and shifter carry-out from Rm, the shift type and either a 5-bit immediate or Rs[7:0]. Sits between register read and the ALU, consuming register-file read data and producing the ALU's second operand. It covers all ARMv6 special encodings: LSR/ASR #32 via imm 0, RRX, and register shift amounts 0, 32 and >32. It uses a valid/ready handshake with a one-entry output register, and supports flush.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous; discards the held result and any same-cycle input
- in_valid  input  1  request present
- in_ready  output  1  stage can accept this cycle
- rm_data  input  32  value to shift
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX
- shift_by_reg  input  1  0: amount = imm_shift; 1: amount = rs_data
- imm_shift  input  5  immediate amount
- rs_data  input  8  register amount (Rs[7:0])
- carry_in  input  1  current CPSR C flag
- out_valid  output  1  operand valid
- out_ready  input  1  ALU accepts operand
- operand  output  32  shifter operand
- shifter_carry  output  1  shifter carry-out

## Operation
- **Immediate shifts** (shift_by_reg = 0), n = imm_shift:
  - LSL: n = 0 gives Rm and C = carry_in; otherwise Rm<<n and C = Rm[32-n].
  - LSR: n = 0 means a shift of 32, giving 0 and C = Rm[31]; otherwise Rm>>n and C = Rm[n-1].
  - ASR: n = 0 means a shift of 32, giving 32 copies of Rm[31] and C = Rm[31]; otherwise arithmetic shift right by n and C = Rm[n-1].
  - ROR: n = 0 is RRX, giving {carry_in, Rm[31:1]} and C = Rm[0]; otherwise rotate right by n and C = Rm[n-1].
- **Register shifts** (shift_by_reg = 1), s = rs_data (0..255):
  - s = 0, any type: Rm and C = carry_in.
  - LSL: s < 32 as the immediate case; s = 32 gives 0 and C = Rm[0]; s > 32 gives 0 and C = 0.
  - LSR: s < 32 as the immediate case; s = 32 gives 0 and C = Rm[31]; s > 32 gives 0 and C = 0.
  - ASR: s ≥ 32 gives sign-fill and C = Rm[31].
  - ROR: if s[4:0] = 0 (s nonzero), Rm and C = Rm[31]; otherwise rotate by s[4:0] and C = Rm[s[4:0]-1].
- Only rs_data[7:0] is significant; amount compares are 8-bit unsigned.
- **Handshake:**
  - in_ready = !out_valid | out_ready (combinational; no dependency on in_valid).
  - Accept = in_valid & in_ready. On accept, the computed operand and carry are registered and out_valid is set the next cycle.
  - If out_valid & out_ready & !accept, out_valid clears.
  - While out_valid & !out_ready, operand, shifter_carry and out_valid hold stable. Inputs are ignored (in_ready = 0).
- **Flush:** the next cycle has out_valid = 0 regardless of in_valid/out_ready. flush has priority over accept. in_ready is unaffected by flush.
- **Reset:** has priority over flush. The cycle after reset is asserted: out_valid = 0, operand = 0, shifter_carry = 0. in_ready is then 1.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 operation per cycle when out_ready is held high. There are no bubbles on back-to-back transfers.
- All shift/carry logic is combinational from inputs to the output register. No input-to-output combinational path except in_ready from out_valid/out_ready.
- A simultaneous drain and accept (out_valid & out_ready & in_valid) replaces the held result in the same edge. out_valid stays 1.
- Reset mid-stall drops the held result; no output is produced for it.

## Test plan
- **Reset:** assert reset for 2 cycles with in_valid = 1 → out_valid = 0, operand = 0, shifter_carry = 0, in_ready = 1 after release.
- **Immediate specials:**
  - Rm = 0x8000_0001, carry_in = 0, each with imm 0:
    - LSL → 0x8000_0001 with C = 0.
    - LSR → 0x0000_0000 with C = 1.
    - ASR → 0xFFFF_FFFF with C = 1.
  - Rm = 0x8000_0001, carry_in = 1: ROR imm 0 (RRX) → 0xC000_0000 with C = 1.
- **Register amounts,** Rm = 0x8000_0001:
  - LSL s = 32 → 0 with C = 1.
  - LSL s = 33 → 0 with C = 0.
  - LSR s = 200 → 0 with C = 0.
  - ASR s = 255 → 0xFFFF_FFFF with C = 1.
  - ROR s = 64 → 0x8000_0001 with C = 1.
  - ROR s = 4 → 0x1800_0000 with C = 0.
  - Any type with s = 0 and carry_in = 1 → Rm with C = 1.
- **Normal shift:** Rm = 0xF000_000F, LSR imm 4 → 0x0F00_0000 with C = 1. ASR imm 4 → 0xFF00_0000 with C = 1.
- **Backpressure:**
  - Stream 4 ops with out_ready = 1 → 4 results on consecutive cycles.
  - Drop out_ready for 3 cycles with in_valid high → in_ready = 0, outputs held. On release, the next op is accepted the same cycle and the sequence order is preserved.
- **Flush during stall:** out_valid = 1, out_ready = 0, flush = 1 with in_valid = 1 → next cycle out_valid = 0. The flushed input never appears. The following accept produces a normal result.
